vga_port_regs: RTL and testbench

- CPU-facing I/O register file that drives the video scanout block.
- Decodes VGA-compatible port writes and reads:
  - CRTC index/data: cursor position and cursor shape.
  - Mode register: videomode.
  - DAC write/read ports: 3-phase RGB palette access.
  - Status port: latched vertical-retrace flag.
- Sits between the CPU I/O bus and the scanout block's videomode/cursor/cursor_start/cursor_end inputs.
- Owns the write side of the 256x12 palette RAM; the scanout block reads the other port.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_dac_seq.sv | 91 +++++++++
 rtl/vga_port_regs.sv | 117 +++++++++++
 tb/tb_vga_port_regs.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA I/O register block: port map, CRTC
// register indices, DAC phase encoding and palette colour-width conversion.
package vga_pkg;

  localparam logic [15:0] P_CRTC_IDX = 16'h03D4;
  localparam logic [15:0] P_CRTC_DAT = 16'h03D5;
  localparam logic [15:0] P_MODE     = 16'h03D8;
  localparam logic [15:0] P_STATUS   = 16'h03DA;
  localparam logic [15:0] P_DAC_RIDX = 16'h03C7;
  localparam logic [15:0] P_DAC_WIDX = 16'h03C8;
  localparam logic [15:0] P_DAC_DATA = 16'h03C9;

  localparam logic [4:0] CRTC_CUR_START = 5'h0A;
  localparam logic [4:0] CRTC_CUR_END   = 5'h0B;
  localparam logic [4:0] CRTC_CUR_HI    = 5'h0E;
  localparam logic [4:0] CRTC_CUR_LO    = 5'h0F;

  typedef enum logic [1:0] {
    PhR = 2'd0,
    PhG = 2'd1,
    PhB = 2'd2
  } dac_phase_e;

  // The palette stores 4 bits per gun; the CPU sees the classic 6-bit value.
  function automatic logic [3:0] col6to4(input logic [7:0] v);
    return v[5:2];
  endfunction

  function automatic logic [7:0] col4to6(input logic [3:0] c);
    return {2'b00, c, c[3:2]};
  endfunction

endpackage

// File: rtl/vga_dac_seq.sv
// DAC port sequencer: write/read index registers, 3-phase RGB triplet handling
// and the single-cycle palette write pulse.
module vga_dac_seq
  import vga_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        widx_wr,
  input  logic        ridx_wr,
  input  logic        data_wr,
  input  logic        data_rd,
  input  logic [7:0]  wdata,
  input  logic [11:0] dac_rq,
  output logic [7:0]  widx,
  output logic        dac_we,
  output logic [7:0]  dac_wa,
  output logic [11:0] dac_wd,
  output logic [7:0]  dac_ra,
  output logic [7:0]  rd_data
);

  dac_phase_e wphase, rphase;
  logic [7:0] ridx;
  logic [3:0] lat_r, lat_g;
  logic [3:0] rd_comp;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wphase <= PhR;
      rphase <= PhR;
      widx   <= 8'h00;
      ridx   <= 8'h00;
      lat_r  <= 4'h0;
      lat_g  <= 4'h0;
      dac_we <= 1'b0;
      dac_wa <= 8'h00;
      dac_wd <= 12'h000;
    end else begin
      dac_we <= 1'b0;
      if (widx_wr) begin
        widx   <= wdata;
        wphase <= PhR;
      end else if (data_wr) begin
        case (wphase)
          PhR: begin
            lat_r  <= col6to4(wdata);
            wphase <= PhG;
          end
          PhG: begin
            lat_g  <= col6to4(wdata);
            wphase <= PhB;
          end
          default: begin
            dac_we <= 1'b1;
            dac_wa <= widx;
            dac_wd <= {lat_r, lat_g, col6to4(wdata)};
            widx   <= widx + 8'd1;
            wphase <= PhR;
          end
        endcase
      end

      if (ridx_wr) begin
        ridx   <= wdata;
        rphase <= PhR;
      end else if (data_rd) begin
        case (rphase)
          PhR:     rphase <= PhG;
          PhG:     rphase <= PhB;
          default: begin
            rphase <= PhR;
            ridx   <= ridx + 8'd1;
          end
        endcase
      end
    end
  end

  always_comb begin
    rd_comp = dac_rq[3:0];
    case (rphase)
      PhR:     rd_comp = dac_rq[11:8];
      PhG:     rd_comp = dac_rq[7:4];
      default: rd_comp = dac_rq[3:0];
    endcase
  end

  assign rd_data = col4to6(rd_comp);
  assign dac_ra  = ridx;

endmodule

// File: rtl/vga_port_regs.sv
// CPU-facing VGA I/O register file: port decode, CRTC cursor registers, mode
// register, retrace status latch and the registered read-data path.
module vga_port_regs
  import vga_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] port_a,
  input  logic        port_w,
  input  logic        port_r,
  input  logic [7:0]  port_o,
  output logic [7:0]  port_i,
  input  logic        vretrace,
  output logic [7:0]  videomode,
  output logic [11:0] cursor,
  output logic [3:0]  cursor_start,
  output logic [3:0]  cursor_end,
  output logic [7:0]  dac_wa,
  output logic [11:0] dac_wd,
  output logic        dac_we,
  output logic [7:0]  dac_ra,
  input  logic [11:0] dac_rq
);

  logic       rd;
  logic [4:0] crtc_idx;
  logic       retrace;
  logic [7:0] dac_widx;
  logic [7:0] dac_rdata;
  logic [7:0] crtc_rdata;
  logic [7:0] rdata;

  // A simultaneous write wins; the read is dropped entirely.
  assign rd = port_r & ~port_w;

  vga_dac_seq u_dac_seq (
    .clock   (clock),
    .reset_n (reset_n),
    .widx_wr (port_w && port_a == P_DAC_WIDX),
    .ridx_wr (port_w && port_a == P_DAC_RIDX),
    .data_wr (port_w && port_a == P_DAC_DATA),
    .data_rd (rd && port_a == P_DAC_DATA),
    .wdata   (port_o),
    .dac_rq  (dac_rq),
    .widx    (dac_widx),
    .dac_we  (dac_we),
    .dac_wa  (dac_wa),
    .dac_wd  (dac_wd),
    .dac_ra  (dac_ra),
    .rd_data (dac_rdata)
  );

  always_comb begin
    crtc_rdata = 8'h00;
    case (crtc_idx)
      CRTC_CUR_START: crtc_rdata = {4'h0, cursor_start};
      CRTC_CUR_END:   crtc_rdata = {4'h0, cursor_end};
      CRTC_CUR_HI:    crtc_rdata = {4'h0, cursor[11:8]};
      CRTC_CUR_LO:    crtc_rdata = cursor[7:0];
      default:        crtc_rdata = 8'h00;
    endcase
  end

  always_comb begin
    rdata = 8'hFF;
    case (port_a)
      P_CRTC_IDX: rdata = {3'b000, crtc_idx};
      P_CRTC_DAT: rdata = crtc_rdata;
      P_MODE:     rdata = videomode;
      P_STATUS:   rdata = {4'h0, retrace, 2'b00, retrace};
      P_DAC_WIDX: rdata = dac_widx;
      P_DAC_DATA: rdata = dac_rdata;
      default:    rdata = 8'hFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crtc_idx     <= 5'h00;
      videomode    <= 8'h00;
      cursor       <= 12'h000;
      cursor_start <= 4'hE;
      cursor_end   <= 4'hF;
      retrace      <= 1'b0;
      port_i       <= 8'h00;
    end else begin
      if (port_w) begin
        case (port_a)
          P_CRTC_IDX: crtc_idx <= port_o[4:0];
          P_CRTC_DAT: begin
            case (crtc_idx)
              CRTC_CUR_START: cursor_start <= port_o[3:0];
              CRTC_CUR_END:   cursor_end   <= port_o[3:0];
              CRTC_CUR_HI:    cursor[11:8] <= port_o[3:0];
              CRTC_CUR_LO:    cursor[7:0]  <= port_o;
              default:        ;
            endcase
          end
          P_MODE:  videomode <= port_o;
          default: ;
        endcase
      end

      if (rd) begin
        port_i <= rdata;
      end

      // A retrace pulse coinciding with a status read still leaves the flag set.
      if (vretrace) begin
        retrace <= 1'b1;
      end else if (rd && port_a == P_STATUS) begin
        retrace <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_port_regs.sv
// Scoreboard bench for vga_port_regs: read results and palette writes are
// queued when stimulus is driven and checked when the DUT produces them.
module tb_vga_port_regs;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] port_a;
  logic        port_w;
  logic        port_r;
  logic [7:0]  port_o;
  logic [7:0]  port_i;
  logic        vretrace;
  logic [7:0]  videomode;
  logic [11:0] cursor;
  logic [3:0]  cursor_start;
  logic [3:0]  cursor_end;
  logic [7:0]  dac_wa;
  logic [11:0] dac_wd;
  logic        dac_we;
  logic [7:0]  dac_ra;
  logic [11:0] dac_rq;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]  rd_q[$];
  logic [19:0] we_q[$];
  logic        rd_pend = 1'b0;

  always #5 clock = ~clock;

  vga_port_regs dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .port_a       (port_a),
    .port_w       (port_w),
    .port_r       (port_r),
    .port_o       (port_o),
    .port_i       (port_i),
    .vretrace     (vretrace),
    .videomode    (videomode),
    .cursor       (cursor),
    .cursor_start (cursor_start),
    .cursor_end   (cursor_end),
    .dac_wa       (dac_wa),
    .dac_wd       (dac_wd),
    .dac_we       (dac_we),
    .dac_ra       (dac_ra),
    .dac_rq       (dac_rq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    port_a = a;
    port_o = d;
    port_w = 1'b1;
    @(negedge clock);
    port_w = 1'b0;
  endtask

  task automatic io_rd(input logic [15:0] a, input logic [7:0] exp);
    @(negedge clock);
    port_a = a;
    port_r = 1'b1;
    rd_q.push_back(exp);
    @(negedge clock);
    port_r = 1'b0;
  endtask

  // Read data is due one clock after the accepted read strobe.
  always @(posedge clock) rd_pend <= reset_n && port_r && !port_w;

  always @(negedge clock) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) check_eq("unexpected_read", 32'(port_i), 32'hDEAD);
      else check_eq("port_i", 32'(port_i), 32'(rd_q.pop_front()));
    end
    if (dac_we) begin
      if (we_q.size() == 0) check_eq("spurious_dac_we", 32'({dac_wa, dac_wd}), 32'hDEAD);
      else check_eq("dac_wa_wd", 32'({dac_wa, dac_wd}), 32'(we_q.pop_front()));
    end
  end

  initial begin
    reset_n  = 1'b0;
    port_a   = 16'h0000;
    port_w   = 1'b0;
    port_r   = 1'b0;
    port_o   = 8'h00;
    vretrace = 1'b0;
    dac_rq   = 12'hA3C;
    repeat (2) @(negedge clock);
    check_eq("rst_cursor_start", 32'(cursor_start), 32'hE);
    check_eq("rst_cursor_end", 32'(cursor_end), 32'hF);
    check_eq("rst_videomode", 32'(videomode), 32'h0);
    check_eq("rst_cursor", 32'(cursor), 32'h0);
    check_eq("rst_dac_we", 32'(dac_we), 32'h0);
    check_eq("rst_dac_ra", 32'(dac_ra), 32'h0);
    check_eq("rst_port_i", 32'(port_i), 32'h0);
    reset_n = 1'b1;

    // CRTC cursor position and shape
    io_wr(16'h03D4, 8'h0E);
    io_wr(16'h03D5, 8'h07);
    io_wr(16'h03D4, 8'h0F);
    io_wr(16'h03D5, 8'hD0);
    check_eq("cursor", 32'(cursor), 32'h7D0);
    io_rd(16'h03D5, 8'hD0);
    io_rd(16'h03D4, 8'h0F);
    io_wr(16'h03D4, 8'h0A);
    io_wr(16'h03D5, 8'hF5);
    check_eq("cursor_start", 32'(cursor_start), 32'h5);
    io_rd(16'h03D5, 8'h05);
    io_wr(16'h03D4, 8'h03);
    io_rd(16'h03D5, 8'h00);

    // DAC write triplet at index 0xFF; index wraps
    io_wr(16'h03C8, 8'hFF);
    io_wr(16'h03C9, 8'h3F);
    io_wr(16'h03C9, 8'h00);
    we_q.push_back({8'hFF, 12'hF08});
    io_wr(16'h03C9, 8'h20);
    io_rd(16'h03C8, 8'h00);

    // Reset mid-triplet discards the partial write
    io_wr(16'h03C9, 8'h3F);
    io_wr(16'h03C9, 8'h3F);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_eq("rst_mid_cursor_start", 32'(cursor_start), 32'hE);
    io_wr(16'h03C9, 8'h04);
    io_wr(16'h03C9, 8'h08);
    we_q.push_back({8'h00, 12'h123});
    io_wr(16'h03C9, 8'h0C);

    // DAC read triplet
    io_wr(16'h03C7, 8'h05);
    check_eq("dac_ra_set", 32'(dac_ra), 32'h05);
    io_rd(16'h03C9, 8'h2A);
    io_rd(16'h03C9, 8'h0C);
    io_rd(16'h03C9, 8'h33);
    check_eq("dac_ra_inc", 32'(dac_ra), 32'h06);

    // Retrace latch
    @(negedge clock);
    vretrace = 1'b1;
    @(negedge clock);
    vretrace = 1'b0;
    io_rd(16'h03DA, 8'h09);
    io_rd(16'h03DA, 8'h00);
    @(negedge clock);
    port_a   = 16'h03DA;
    port_r   = 1'b1;
    vretrace = 1'b1;
    rd_q.push_back(8'h00);
    @(negedge clock);
    port_r   = 1'b0;
    vretrace = 1'b0;
    io_rd(16'h03DA, 8'h09);

    // Mode register and simultaneous strobes
    io_wr(16'h03D8, 8'h04);
    check_eq("videomode", 32'(videomode), 32'h04);
    io_rd(16'h03D8, 8'h04);
    @(negedge clock);
    port_a = 16'h03D8;
    port_o = 8'h11;
    port_w = 1'b1;
    port_r = 1'b1;
    @(negedge clock);
    port_w = 1'b0;
    port_r = 1'b0;
    check_eq("wr_rd_videomode", 32'(videomode), 32'h11);
    check_eq("wr_rd_port_i_hold", 32'(port_i), 32'h04);

    // Unmapped addresses
    io_wr(16'h03D0, 8'h55);
    check_eq("unmapped_wr", 32'(videomode), 32'h11);
    io_rd(16'h03D0, 8'hFF);

    repeat (3) @(negedge clock);
    check_eq("rd_q_drained", 32'(rd_q.size()), 32'h0);
    check_eq("we_q_drained", 32'(we_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
